cpu_fetch_unit: RTL
===================

# cpu_fetch_unit

Instruction fetch stage of the 8-bit CPU, directly upstream of `cpu_instruction_decoder`. It reads the opcode byte at the program counter and presents it on `opcode`. It samples the decoder's `instr_length` and fetches 0–2 operand bytes over a byte-wide memory read port. It then offers the assembled instruction to the execute stage with a valid/ready handshake, and handles PC redirects (branch/jump/call/ret) and halt.

## Interface
- `ADDR_WIDTH`, 16, width of program counter and memory address.
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `mem_addr`  out  ADDR_WIDTH  — read address, equal to the internal fetch address register.
- `mem_rd`  out  1  — read request; high only in FETCH_OP, FETCH_B1 and FETCH_B2.
- `mem_rdata`  in  8  — read data; valid in any cycle where `mem_rd & mem_ready`.
- `mem_ready`  in  1  — read completes this cycle; the request is held until ready.
- `opcode`  out  8  — registered opcode; wired to the decoder's `instruction` input.
- `instr_length`  in  2  — decoder length for `opcode`; the value 0 is treated as 1.
- `operand_lo`  out  8  — byte at `pc+1`, or 0 if unused.
- `operand_hi`  out  8  — byte at `pc+2`, or 0 if unused.
- `pc`  out  ADDR_WIDTH  — address of the current instruction's opcode.
- `next_pc`  out  ADDR_WIDTH  — `pc + length`, modulo 2^ADDR_WIDTH; valid while `instr_valid`.
- `instr_valid`  out  1  — instruction bundle available.
- `instr_ready`  in  1  — execute stage accepts the bundle.
- `redirect`  in  1  — load a new PC and flush.
- `redirect_pc`  in  ADDR_WIDTH  — target of the redirect.
- `halt`  in  1  — stop fetching; sampled only on a handshake.
- `halted`  out  1  — the unit is in HALTED.

## Operation
- States: IDLE, FETCH_OP, DECODE, FETCH_B1, FETCH_B2, VALID, HALTED.
- Reset (async) values:
  - `pc` = fetch_addr = 0; `opcode`, `operand_lo`, `operand_hi` = 0.
  - State = IDLE; `mem_rd` = `instr_valid` = `halted` = 0.
  - IDLE goes to FETCH_OP on the first clock edge after reset is released.
- FETCH_OP: `mem_rd`=1, `mem_addr`=fetch_addr.
  - On `mem_ready`: `opcode`←`mem_rdata`; both operands←0; fetch_addr+1; go to DECODE.
- DECODE: no memory access. Sample `instr_length`, latch it as len (0 becomes 1).
  - len 1 → VALID; len 2 or 3 → FETCH_B1.
- FETCH_B1: on `mem_ready`: `operand_lo`←`mem_rdata`; fetch_addr+1.
  - len 3 → FETCH_B2, otherwise → VALID.
- FETCH_B2: on `mem_ready`: `operand_hi`←`mem_rdata`; fetch_addr+1; go to VALID.
- VALID: `instr_valid`=1. `opcode`, operands, `pc` and `next_pc` are held stable until `instr_ready`.
  - On handshake: `pc`←`next_pc` (equal to fetch_addr).
  - If `halt`=1 → HALTED, otherwise → FETCH_OP.
- HALTED: `mem_rd`=0, `instr_valid`=0, `halted`=1. Exit only by reset; `redirect` is ignored here.
- Redirect, in any state except HALTED:
  - `pc`←`redirect_pc`, fetch_addr←`redirect_pc`, state→FETCH_OP.
  - A coincident `mem_ready` is discarded (no register captures `mem_rdata`).
  - A coincident handshake still counts as consumed, but `pc` takes `redirect_pc`.
- Simultaneous `halt` (with handshake) and `redirect`: halt wins and the unit enters HALTED.
- Address arithmetic wraps modulo 2^ADDR_WIDTH, both for fetch_addr increments and for `next_pc`.

## Timing
- With `mem_ready` tied high, counting from the first FETCH_OP cycle (cycle 0):
  - 1-byte instruction: `instr_valid` in cycle 2.
  - 2-byte instruction: cycle 3.
  - 3-byte instruction: cycle 4.
- Each memory wait cycle adds exactly one cycle.
- Back-to-back throughput with `instr_ready`=1: one instruction per (len+2) cycles.
- `opcode` changes only on the FETCH_OP capture edge, so the decoder output is stable for the whole of DECODE.
- `instr_valid` falls in the cycle after the handshake edge, or after the redirect edge.
- `mem_addr` and `mem_rd` must not change while a request is pending (`mem_rd=1`, `mem_ready=0`), except on redirect.

## Test plan
- Reset, then memory[0]=0x30, ready=1 → `mem_rd` is 0 in IDLE. `instr_valid` in cycle 2 with `opcode`=0x30, operands 0, `pc`=0, `next_pc`=1.
- memory[0..2]={0x10,0x34,0x12}, decoder gives len=3, ready=1 → valid in cycle 4 with `operand_lo`=0x34, `operand_hi`=0x12, `next_pc`=3.
- 0xA5,0x7F with `mem_ready` low for 2 cycles on each byte → valid delayed by 4 cycles. Values stay 0xA5/0x7F; `mem_addr` is held during the waits.
- Hold `instr_ready`=0 for 5 cycles on 0xA5,0x01 → outputs stable throughout. On accept, the next fetch starts at address 2.
- Assert `redirect`, `redirect_pc`=0x0200 mid FETCH_B1 with `mem_ready`=1 → no operand capture. The next cycle is FETCH_OP at 0x0200 and `pc`=0x0200.
- `pc`=0xFFFF with opcode 0xF9 (len 3) → fetches from 0xFFFF, 0x0000, 0x0001; `next_pc`=0x0002. Then 0xF0 accepted with `halt`=1 and `redirect`=1 → `halted`=1, `mem_rd`=0 until reset.

Source files
------------

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: reads opcode and 0-2 operand bytes over a byte-wide
// read port and offers the assembled instruction to execute via valid/ready.
module cpu_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ready,
    output logic [7:0]            opcode,
    input  logic [1:0]            instr_length,
    output logic [7:0]            operand_lo,
    output logic [7:0]            operand_hi,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_OP,
        S_DECODE,
        S_FETCH_B1,
        S_FETCH_B2,
        S_VALID,
        S_HALTED
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   fetch_addr;
    logic [1:0]              len;
    logic                    handshake;
    logic                    redirect_take;

    assign mem_addr      = fetch_addr;
    assign next_pc       = pc + ADDR_WIDTH'(len);
    assign handshake     = (state == S_VALID) && instr_ready;
    assign redirect_take = redirect && (state != S_HALTED);

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:     state_d = S_FETCH_OP;
            S_FETCH_OP: if (mem_ready) state_d = S_DECODE;
            S_DECODE:   state_d = (instr_length > 2'd1) ? S_FETCH_B1 : S_VALID;
            S_FETCH_B1: if (mem_ready) state_d = (len == 2'd3) ? S_FETCH_B2 : S_VALID;
            S_FETCH_B2: if (mem_ready) state_d = S_VALID;
            S_VALID:    if (instr_ready) state_d = halt ? S_HALTED : S_FETCH_OP;
            S_HALTED:   state_d = S_HALTED;
            default:    state_d = S_IDLE;
        endcase
        // Halt accepted on a handshake outranks a coincident redirect.
        if (redirect_take && !(handshake && halt))
            state_d = S_FETCH_OP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            mem_rd      <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            pc          <= '0;
            fetch_addr  <= '0;
            opcode      <= '0;
            operand_lo  <= '0;
            operand_hi  <= '0;
            len         <= 2'd1;
        end else begin
            state       <= state_d;
            mem_rd      <= state_d inside {S_FETCH_OP, S_FETCH_B1, S_FETCH_B2};
            instr_valid <= (state_d == S_VALID);
            halted      <= (state_d == S_HALTED);

            if (redirect_take) begin
                // Any read completing this cycle is dropped.
                pc         <= redirect_pc;
                fetch_addr <= redirect_pc;
            end else begin
                unique case (state)
                    S_FETCH_OP: if (mem_ready) begin
                        opcode     <= mem_rdata;
                        operand_lo <= '0;
                        operand_hi <= '0;
                        fetch_addr <= fetch_addr + ADDR_WIDTH'(1);
                    end
                    S_DECODE: len <= (instr_length == 2'd0) ? 2'd1 : instr_length;
                    S_FETCH_B1: if (mem_ready) begin
                        operand_lo <= mem_rdata;
                        fetch_addr <= fetch_addr + ADDR_WIDTH'(1);
                    end
                    S_FETCH_B2: if (mem_ready) begin
                        operand_hi <= mem_rdata;
                        fetch_addr <= fetch_addr + ADDR_WIDTH'(1);
                    end
                    S_VALID: if (instr_ready) pc <= next_pc;
                    default: ;
                endcase
            end
        end
    end

endmodule
